// File: rtl/proc_io_pkg.sv
// Shared definitions for the processor I/O port: default geometry and data word type.
package proc_io_pkg;

  localparam int DATA_W_DEF = 23;
  localparam int DEPTH_DEF  = 16;
  localparam int STATS_W    = 32;

  typedef logic signed [DATA_W_DEF-1:0] data_t;

endpackage

// File: rtl/proc_io_fifo.sv
// Synchronous FIFO with occupancy count, full and empty flags.
// Read data is show-ahead: rd_data is the head entry whenever the FIFO is non-empty.
// A write into a full FIFO is accepted only when a read is accepted in the same cycle.
module proc_io_fifo #(
  parameter int DATA_W = 23,
  parameter int DEPTH  = 16  // power of two, at least 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     wr_ok,
  output logic                     rd_ok
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = mem[rd_ptr];

  // Pointer and occupancy update; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; empty/count guard every read, so stale words are never visible.
    if (!rst && wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/proc_io_port.sv
// Processor I/O port: an upstream stream feeds a show-ahead input FIFO read by the
// processor on input port 0, and processor writes on output port 0 feed an output FIFO
// drained as a downstream stream. Sticky underflow/overflow flags record lost accesses.
// Optional feature: define PROC_IO_STATS_EN to add in_count/out_count statistics outputs.
module proc_io_port
  import proc_io_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     proc_req_in,
  output logic signed [DATA_W-1:0] proc_io_in,
  input  logic [1:0]               proc_out_en,
  input  logic signed [DATA_W-1:0] proc_io_out,
  input  logic signed [DATA_W-1:0] s_data,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic signed [DATA_W-1:0] m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     underflow,
  output logic                     overflow
`ifdef PROC_IO_STATS_EN
  ,
  output logic [STATS_W-1:0]       in_count,
  output logic [STATS_W-1:0]       out_count
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] in_head;
  logic              in_full;
  logic              in_empty;
  logic [CNT_W-1:0]  in_fifo_count;
  logic              in_wr_ok;
  logic              in_rd_ok;

  logic [DATA_W-1:0] out_head;
  logic              out_full;
  logic              out_empty;
  logic [CNT_W-1:0]  out_fifo_count;
  logic              out_wr_ok;
  logic              out_rd_ok;

  logic [DATA_W-1:0] held_in;

  // Input FIFO: pushed by the upstream stream, popped by processor requests.
  // An empty FIFO never bypasses a same-cycle push to the processor.
  proc_io_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_in_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (s_valid),
    .wr_data (s_data),
    .rd_en   (proc_req_in),
    .rd_data (in_head),
    .full    (in_full),
    .empty   (in_empty),
    .count   (in_fifo_count),
    .wr_ok   (in_wr_ok),
    .rd_ok   (in_rd_ok)
  );

  // Output FIFO: written by the processor on output port 0, drained downstream.
  proc_io_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (proc_out_en[0]),
    .wr_data (proc_io_out),
    .rd_en   (m_ready),
    .rd_data (out_head),
    .full    (out_full),
    .empty   (out_empty),
    .count   (out_fifo_count),
    .wr_ok   (out_wr_ok),
    .rd_ok   (out_rd_ok)
  );

  // A same-cycle pop frees a slot, so a full input FIFO can still accept a push.
  assign s_ready    = !in_full || in_rd_ok;
  assign proc_io_in = in_empty ? held_in : in_head;

  assign m_valid = !out_empty;
  assign m_data  = out_empty ? '0 : out_head;

  // Remember the last word handed to the processor for reads from an empty FIFO.
  always_ff @(posedge clk) begin
    if (rst)           held_in <= '0;
    else if (in_rd_ok) held_in <= in_head;
  end

  // Sticky error flags: cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      underflow <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (proc_req_in && in_empty)       underflow <= 1'b1;
      if (proc_out_en[0] && !out_wr_ok)  overflow  <= 1'b1;
    end
  end

`ifdef PROC_IO_STATS_EN
  // Statistics: successful processor pops and successful output writes, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_count  <= '0;
      out_count <= '0;
    end else begin
      if (in_rd_ok)  in_count  <= in_count + 1'b1;
      if (out_wr_ok) out_count <= out_count + 1'b1;
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

  // Status signals not needed by this block, plus the ignored output-enable bit.
  logic unused_status;
  assign unused_status = ^{in_fifo_count, out_fifo_count, in_wr_ok, out_rd_ok, proc_out_en[1]};

endmodule
